// File: rtl/gpr_file.sv
// ============================================================================
// Module      : gpr_file
// Description : General-purpose register bank. NREG registers of WIDTH bits,
//               written from the S bus under a one-hot store select, read
//               onto two independent wired-OR buses (A and B). Adds
//               per-register increment and a sticky store-conflict flag.
// Options     : GPR_FILE_BYPASS_EN - when defined, a valid one-hot store is
//               forwarded combinationally onto any bus that selects the
//               register being written in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpr_file #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [NREG-1:0]  SR,
  input  logic [WIDTH-1:0] S_bus,
  input  logic [NREG-1:0]  INC,
  input  logic [NREG-1:0]  RA,
  input  logic [NREG-1:0]  RB,
  output logic [WIDTH-1:0] A_bus,
  output logic [WIDTH-1:0] B_bus,
  output logic             ERR
);

  localparam logic [NREG-1:0]  SEL_ONE = {{(NREG-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] INC_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic             err_q;
  logic             err_d;

  logic             sr_any;
  logic             sr_onehot;
  logic             sr_conflict;

  // Classify the store select: idle, single valid store, or conflict.
  // A vector with more than one bit set still has bits left after clearing
  // its lowest set bit.
  always_comb begin
    sr_any      = (SR != '0);
    sr_onehot   = sr_any && ((SR & (SR - SEL_ONE)) == '0);
    sr_conflict = sr_any && !sr_onehot;
  end

  // Next-state: store beats increment; a conflicting select writes nothing
  // but does not suppress increments; the error flag only ever sets.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (sr_onehot && SR[i]) begin
        regs_d[i] = S_bus;
      end else if (INC[i]) begin
        regs_d[i] = regs_q[i] + INC_ONE;
      end
    end
    err_d = err_q | sr_conflict;
  end

  // State registers with asynchronous clear of the whole bank and the flag.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      err_q <= err_d;
    end
  end

  // Read path: each selected register is AND-gated onto its bus and the
  // gated terms are ORed together. Multiple selects are legal by design.
  always_comb begin
    logic [WIDTH-1:0] term;
    A_bus = '0;
    B_bus = '0;
    for (int i = 0; i < NREG; i++) begin
      term = regs_q[i];
`ifdef GPR_FILE_BYPASS_EN
      // Only a legal one-hot store is forwarded; increments never are.
      if (sr_onehot && SR[i]) begin
        term = S_bus;
      end
`endif
      A_bus = A_bus | (term & {WIDTH{RA[i]}});
      B_bus = B_bus | (term & {WIDTH{RB[i]}});
    end
  end

  assign ERR = err_q;

endmodule

`default_nettype wire

// File: tb/tb_gpr_file.sv
// ============================================================================
// Module      : tb_gpr_file
// Description : Self-checking bench for gpr_file. Directed scenarios followed
//               by randomized traffic, compared against a behavioural model
//               of the register bank held in plain arrays.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_gpr_file;

  localparam int WIDTH = 16;
  localparam int NREG  = 8;

  logic             CLK = 1'b0;
  logic             CLR;
  logic [NREG-1:0]  SR;
  logic [WIDTH-1:0] S_bus;
  logic [NREG-1:0]  INC;
  logic [NREG-1:0]  RA;
  logic [NREG-1:0]  RB;
  logic [WIDTH-1:0] A_bus;
  logic [WIDTH-1:0] B_bus;
  logic             ERR;

  gpr_file #(.WIDTH(WIDTH), .NREG(NREG)) dut (
    .CLK   (CLK),
    .CLR   (CLR),
    .SR    (SR),
    .S_bus (S_bus),
    .INC   (INC),
    .RA    (RA),
    .RB    (RB),
    .A_bus (A_bus),
    .B_bus (B_bus),
    .ERR   (ERR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: register contents and sticky error flag.
  logic [WIDTH-1:0] mdl [NREG];
  logic             mdl_err;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Expected bus value for a select vector given the current inputs.
  function automatic logic [WIDTH-1:0] exp_bus(input logic [NREG-1:0] sel);
    logic [WIDTH-1:0] v;
    v = '0;
    if (CLR) return '0;
    for (int i = 0; i < NREG; i++) begin
      if (sel[i]) begin
`ifdef GPR_FILE_BYPASS_EN
        if ($countones(SR) == 1 && SR[i]) v = v | S_bus;
        else                              v = v | mdl[i];
`else
        v = v | mdl[i];
`endif
      end
    end
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) mdl[i] = '0;
    mdl_err = 1'b0;
  endtask

  // Inputs already applied just after a rising edge: check the combinational
  // outputs, advance the model, clock once and land 1ns after the edge.
  task automatic cycle(input string tag);
    logic [WIDTH-1:0] nxt [NREG];
    logic             nerr;
    int               pc;
    if (CLR) model_clear();
    #1;
    check({tag, "/A"}, A_bus, exp_bus(RA));
    check({tag, "/B"}, B_bus, exp_bus(RB));
    check({tag, "/ERR"}, {15'b0, ERR}, {15'b0, mdl_err});
    pc   = $countones(SR);
    nerr = mdl_err || (pc > 1);
    for (int i = 0; i < NREG; i++) begin
      if (pc == 1 && SR[i])  nxt[i] = S_bus;
      else if (INC[i])       nxt[i] = mdl[i] + 16'd1;
      else                   nxt[i] = mdl[i];
    end
    @(posedge CLK);
    #1;
    if (CLR) begin
      model_clear();
    end else begin
      for (int i = 0; i < NREG; i++) mdl[i] = nxt[i];
      mdl_err = nerr;
    end
  endtask

  task automatic idle_inputs();
    SR = '0; INC = '0; RA = '0; RB = '0; S_bus = '0;
  endtask

  task automatic write(input int r, input logic [WIDTH-1:0] v);
    idle_inputs();
    SR    = NREG'(1) << r;
    S_bus = v;
    cycle("write");
    idle_inputs();
  endtask

  // Read back every register through both buses with the bank idle.
  task automatic dump(input string tag);
    idle_inputs();
    for (int i = 0; i < NREG; i++) begin
      RA = NREG'(1) << i;
      RB = NREG'(1) << ((i + 3) % NREG);
      #1;
      check({tag, "/dumpA"}, A_bus, CLR ? '0 : mdl[i]);
      check({tag, "/dumpB"}, B_bus, CLR ? '0 : mdl[(i + 3) % NREG]);
    end
    idle_inputs();
    @(posedge CLK);
    #1;
  endtask

  task automatic read_reg(input int r, output logic [WIDTH-1:0] v);
    RA = NREG'(1) << r;
    #1;
    v  = A_bus;
    RA = '0;
  endtask

  initial begin
    logic [WIDTH-1:0] rv;
    logic [NREG-1:0]  tmp;
    CLR = 1'b1;
    idle_inputs();
    model_clear();
    repeat (2) @(posedge CLK);
    #1;
    // Reset state
    RA = '1; RB = '1;
    #1;
    check("rst/A", A_bus, 16'h0000);
    check("rst/B", B_bus, 16'h0000);
    check("rst/ERR", {15'b0, ERR}, 16'h0000);
    idle_inputs();
    CLR = 1'b0;
    @(posedge CLK);
    #1;

    // Write and dual read
    write(2, 16'hBEEF);
    write(3, 16'h00F0);
    RA = 8'h04; RB = 8'h08;
    #1;
    check("wr/A", A_bus, 16'hBEEF);
    check("wr/B", B_bus, 16'h00F0);
    RA = 8'h0C;
    #1;
    check("wr/Aor", A_bus, 16'hBEEF | 16'h00F0);
    @(posedge CLK);
    #1;

    // Read latency (reg1 still 0)
    idle_inputs();
    SR = 8'h02; S_bus = 16'h5555; RA = 8'h02;
    #1;
`ifdef GPR_FILE_BYPASS_EN
    check("lat/same", A_bus, 16'h5555);
`else
    check("lat/same", A_bus, 16'h0000);
`endif
    cycle("lat");
    idle_inputs();
    RA = 8'h02;
    #1;
    check("lat/after", A_bus, 16'h5555);
    @(posedge CLK);
    #1;

    // Conflict
    write(0, 16'h1111);
    write(1, 16'h2222);
    SR = 8'h03; S_bus = 16'hAAAA;
    cycle("conf");
    idle_inputs();
    read_reg(0, rv); check("conf/r0", rv, 16'h1111);
    read_reg(1, rv); check("conf/r1", rv, 16'h2222);
    check("conf/ERR", {15'b0, ERR}, 16'h0001);
    for (int k = 0; k < 10; k++) cycle("conf_idle");
    check("conf/ERRsticky", {15'b0, ERR}, 16'h0001);

    // Asynchronous clear mid-cycle with nonzero registers
    @(negedge CLK);
    #2;
    CLR = 1'b1;
    #1;
    check("aclr/ERR", {15'b0, ERR}, 16'h0000);
    RA = 8'h04; RB = 8'h0F;
    #0.5;
    check("aclr/A", A_bus, 16'h0000);
    check("aclr/B", B_bus, 16'h0000);
    model_clear();
    // CLR held high blocks a store across an edge
    SR = 8'h01; S_bus = 16'h1234; RA = 8'h01;
    @(posedge CLK);
    #1;
    idle_inputs();
    CLR = 1'b0;
    read_reg(0, rv); check("aclr/r0", rv, 16'h0000);
    @(posedge CLK);
    #1;
    dump("aclr");

    // Increment wrap and store-beats-increment
    write(5, 16'hFFFF);
    INC = 8'h20;
    cycle("wrap");
    idle_inputs();
    read_reg(5, rv); check("wrap/r5", rv, 16'h0000);
    write(6, 16'h0010);
    SR = 8'h40; S_bus = 16'h0100; INC = 8'h40;
    cycle("stinc");
    idle_inputs();
    read_reg(6, rv); check("stinc/r6", rv, 16'h0100);

    // Conflict plus increment
    write(2, 16'h0007);
    write(0, 16'hA0A0);
    write(4, 16'h0404);
    SR = 8'h11; INC = 8'h04; S_bus = 16'hFFFF;
    cycle("cinc");
    idle_inputs();
    read_reg(2, rv); check("cinc/r2", rv, 16'h0008);
    read_reg(0, rv); check("cinc/r0", rv, 16'hA0A0);
    read_reg(4, rv); check("cinc/r4", rv, 16'h0404);
    check("cinc/ERR", {15'b0, ERR}, 16'h0001);
    @(posedge CLK);
    #1;
    dump("cinc");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int kind;
      kind  = $urandom_range(0, 9);
      S_bus = WIDTH'($urandom);
      if (kind < 3)       SR = '0;
      else if (kind < 8)  SR = NREG'(1) << $urandom_range(0, NREG - 1);
      else begin
        tmp = NREG'($urandom);
        SR  = ($countones(tmp) > 1) ? tmp : 8'h81;
      end
      INC = NREG'($urandom) & NREG'($urandom);
      RA  = ($urandom_range(0, 1) == 1) ? NREG'(1) << $urandom_range(0, NREG - 1)
                                         : NREG'($urandom);
      RB  = NREG'(1) << $urandom_range(0, NREG - 1);
      CLR = ($urandom_range(0, 59) == 0);
      cycle("rnd");
      CLR = 1'b0;
      if (n % 50 == 49) dump("rnd");
    end
    idle_inputs();
    dump("final");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
